// File: rtl/ysyx_24090003_idu_stage.sv
// RV32I/RV32E decode stage: combinational field split, immediate and format decode
// feeding a 2-entry skid buffer so that in_ready comes straight from a flop.
module ysyx_24090003_idu_stage #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned PC_W   = 32
) (
   input  logic              cpu_clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst,
   input  logic [PC_W-1:0]   pc_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   pc_out,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic [REG_AW-1:0] rd,
   output logic [6:0]        opcode,
   output logic [2:0]        funct3,
   output logic [6:0]        funct7,
   output logic [31:0]       imm,
   output logic [2:0]        fmt,
   output logic              illegal
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam bit         RV32E = (REG_AW < 5);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [6:0]        opcode;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [31:0]       imm;
      logic [2:0]        fmt;
      logic              illegal;
   } rec_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   rec_t   dec;
   rec_t   head_q;
   rec_t   skid_q;
   state_t state_q;
   state_t state_d;
   logic   load_head;
   logic   load_skid;
   logic   pop_skid;
   logic   xfer_in;
   logic   xfer_out;
   logic   known;
   logic   use_rs1;
   logic   use_rs2;
   logic   use_rd;
   logic   hi_reg;
   logic [2:0]  fmt_c;
   logic [31:0] imm_c;

   // Decode of the incoming instruction; illegal encodings collapse to fmt=R, imm=0
   always_comb begin
      dec        = '0;
      known      = 1'b1;
      fmt_c      = FMT_R;
      imm_c      = '0;
      dec.pc     = pc_in;
      dec.rs1    = inst[15 +: REG_AW];
      dec.rs2    = inst[20 +: REG_AW];
      dec.rd     = inst[7 +: REG_AW];
      dec.opcode = inst[6:0];
      dec.funct3 = inst[14:12];
      dec.funct7 = inst[31:25];
      case (inst[6:0])
         7'b0110011:                                       fmt_c = FMT_R;
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
         7'b0001111:                                       fmt_c = FMT_I;
         7'b0100011:                                       fmt_c = FMT_S;
         7'b1100011:                                       fmt_c = FMT_B;
         7'b0110111, 7'b0010111:                           fmt_c = FMT_U;
         7'b1101111:                                       fmt_c = FMT_J;
         default:                                          known = 1'b0;
      endcase
      case (fmt_c)
         FMT_I:   imm_c = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm_c = {inst[31:12], 12'b0};
         FMT_J:   imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm_c = '0;
      endcase
      use_rs1 = (fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
      use_rs2 = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
      use_rd  = (fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_U) || (fmt_c == FMT_J);
      // RV32E only has x0-x15, so bit 4 of any used register field is an illegal encoding
      hi_reg  = (use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11]);
      dec.illegal = !known || (inst[1:0] != 2'b11) || (RV32E && hi_reg);
      dec.fmt     = dec.illegal ? FMT_R : fmt_c;
      dec.imm     = dec.illegal ? 32'd0 : imm_c;
   end

   assign xfer_in  = in_valid && in_ready;
   assign xfer_out = out_valid && out_ready;

   always_ff @(posedge cpu_clk) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // Occupancy FSM; head is always the oldest entry, skid holds the younger one when full
   always_comb begin
      state_d   = state_q;
      load_head = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (xfer_in) begin
                  state_d   = ST_ONE;
                  load_head = 1'b1;
               end
            end
            ST_ONE: begin
               if (xfer_in && !xfer_out) begin
                  state_d   = ST_TWO;
                  load_skid = 1'b1;
               end else if (xfer_in && xfer_out) begin
                  load_head = 1'b1;
               end else if (xfer_out) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (xfer_out) begin
                  state_d  = ST_ONE;
                  pop_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         head_q    <= '0;
         skid_q    <= '0;
      end else begin
         in_ready  <= (state_d != ST_TWO);
         out_valid <= (state_d != ST_EMPTY);
         if (load_head)     head_q <= dec;
         else if (pop_skid) head_q <= skid_q;
         if (load_skid)     skid_q <= dec;
      end
   end

   assign pc_out  = head_q.pc;
   assign rs1     = head_q.rs1;
   assign rs2     = head_q.rs2;
   assign rd      = head_q.rd;
   assign opcode  = head_q.opcode;
   assign funct3  = head_q.funct3;
   assign funct7  = head_q.funct7;
   assign imm     = head_q.imm;
   assign fmt     = head_q.fmt;
   assign illegal = head_q.illegal;

endmodule
